// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes,
// ALU control codes and datapath mux selects.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. illegal_instr exists only when
// ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_w;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_control;
   logic [1:0] imm_src;
   logic       reg_w;
   logic       instr_done;
`ifdef ILLEGAL_TRAP_EN
   logic       illegal_instr;
`endif

   modport master (
      input  op, funct3, funct7b5, zero, mem_ready,
      output pc_write, adr_src, mem_w, ir_write, result_src, alu_src_a,
             alu_src_b, alu_control, imm_src, reg_w, instr_done
`ifdef ILLEGAL_TRAP_EN
      , output illegal_instr
`endif
   );

   modport slave (
      output op, funct3, funct7b5, zero, mem_ready,
      input  pc_write, adr_src, mem_w, ir_write, result_src, alu_src_a,
             alu_src_b, alu_control, imm_src, reg_w, instr_done
`ifdef ILLEGAL_TRAP_EN
      , input illegal_instr
`endif
   );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decode from the FSM's alu_op and the instruction funct fields.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 selects sub only for R-type; addi reuses that bit as imm
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle main controller FSM with memory-ready stalls.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module multicycle_ctrl
   import rv_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           srst,
   multicycle_ctrl_if.master bus
);
   state_t  state, next_state;
   alu_op_t alu_op;
   logic    pc_update, branch, ir_write_raw, mem_w_raw, reg_w_raw, done_raw;
   logic    adr_src_q;
   logic [1:0] result_src_q, src_a_q, src_b_q;

   always_ff @(posedge clk or posedge srst) begin
      if (srst) state <= FETCH;
      else      state <= next_state;
   end

   always_comb begin
      next_state   = state;
      alu_op       = ALUOP_ADD;
      pc_update    = 1'b0;
      branch       = 1'b0;
      ir_write_raw = 1'b0;
      mem_w_raw    = 1'b0;
      reg_w_raw    = 1'b0;
      done_raw     = 1'b0;
      adr_src_q    = 1'b0;
      result_src_q = RES_ALUOUT;
      src_a_q      = SRCA_PC;
      src_b_q      = SRCB_RD2;
      case (state)
         FETCH: begin
            ir_write_raw = bus.mem_ready;
            pc_update    = bus.mem_ready;
            src_b_q      = SRCB_FOUR;
            result_src_q = RES_ALU;
            if (bus.mem_ready) next_state = DECODE;
         end
         DECODE: begin
            src_a_q = SRCA_OLDPC;
            src_b_q = SRCB_IMM;
            case (bus.op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_R:         next_state = EXECR;
               OP_I:         next_state = EXECI;
               OP_JAL:       next_state = JAL;
               OP_BEQ:       next_state = BEQ;
`ifdef ILLEGAL_TRAP_EN
               default:      next_state = TRAP;
`else
               default: begin
                  done_raw   = 1'b1;
                  next_state = FETCH;
               end
`endif
            endcase
         end
         MEMADR: begin
            src_a_q    = SRCA_RD1;
            src_b_q    = SRCB_IMM;
            next_state = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src_q = 1'b1;
            if (bus.mem_ready) next_state = MEMWB;
         end
         MEMWB: begin
            result_src_q = RES_RDATA;
            reg_w_raw    = 1'b1;
            done_raw     = 1'b1;
            next_state   = FETCH;
         end
         MEMWRITE: begin
            adr_src_q = 1'b1;
            mem_w_raw = 1'b1;
            if (bus.mem_ready) begin
               done_raw   = 1'b1;
               next_state = FETCH;
            end
         end
         EXECR: begin
            src_a_q    = SRCA_RD1;
            alu_op     = ALUOP_FUNCT;
            next_state = ALUWB;
         end
         EXECI: begin
            src_a_q    = SRCA_RD1;
            src_b_q    = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            next_state = ALUWB;
         end
         ALUWB: begin
            reg_w_raw  = 1'b1;
            done_raw   = 1'b1;
            next_state = FETCH;
         end
         JAL: begin
            src_a_q    = SRCA_OLDPC;
            src_b_q    = SRCB_FOUR;
            pc_update  = 1'b1;
            next_state = ALUWB;
         end
         BEQ: begin
            src_a_q    = SRCA_RD1;
            alu_op     = ALUOP_SUB;
            branch     = 1'b1;
            done_raw   = 1'b1;
            next_state = FETCH;
         end
         TRAP:    next_state = TRAP;
         default: next_state = FETCH;
      endcase
   end

   // Reset masks every enable so an aborted instruction cannot commit.
   assign bus.pc_write   = ~srst & (pc_update | (branch & bus.zero));
   assign bus.ir_write   = ~srst & ir_write_raw;
   assign bus.mem_w      = ~srst & mem_w_raw;
   assign bus.reg_w      = ~srst & reg_w_raw;
   assign bus.instr_done = ~srst & done_raw;
   assign bus.adr_src    = adr_src_q;
   assign bus.result_src = result_src_q;
   assign bus.alu_src_a  = src_a_q;
   assign bus.alu_src_b  = src_b_q;
   assign bus.imm_src    = imm_src_of(bus.op);
`ifdef ILLEGAL_TRAP_EN
   assign bus.illegal_instr = (state == TRAP);
`endif

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (bus.funct3),
      .funct7b5    (bus.funct7b5),
      .op5         (bus.op[5]),
      .alu_control (bus.alu_control)
   );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Vector-table bench for multicycle_ctrl; expected outputs are queued when a
// row is driven and compared on the following falling edge.
module tb_multicycle_ctrl;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw, done, ill;
  } exp_t;

  typedef struct {
    string      name;
    logic       srst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    logic       mr;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic srst = 1'b0;
  int   tests = 0;
  int   failed = 0;
  vec_t vecs[$];
  vec_t sb[$];

  multicycle_ctrl_if ifc();

  multicycle_ctrl dut (
    .clk  (clk),
    .srst (srst),
    .bus  (ifc.master)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic pcw, adr, mw, irw, input logic [1:0] rs, a, b,
                              input logic [2:0] alu, input logic [1:0] imm,
                              input logic rw, done, ill);
    return '{pcw, adr, mw, irw, rs, a, b, alu, imm, rw, done, ill};
  endfunction

  task automatic row(input string n, input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic mr, input exp_t e);
    vec_t v;
    v.name = n; v.srst = r; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic fd(input string n, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                    input logic z, input logic [1:0] imm);
    row({n, "_fetch"},  L, op, f3, f7, z, H, mk(H,L,L,H,2'd2,2'd0,2'd2,3'd0,imm,L,L,L));
    row({n, "_decode"}, L, op, f3, f7, z, H, mk(L,L,L,L,2'd0,2'd1,2'd1,3'd0,imm,L,L,L));
  endtask

  task automatic alu_instr(input string n, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [1:0] b, input logic [2:0] alu);
    fd(n, op, f3, f7, L, 2'd0);
    row({n, "_exec"}, L, op, f3, f7, L, H, mk(L,L,L,L,2'd0,2'd2,b,alu,2'd0,L,L,L));
    row({n, "_wb"},   L, op, f3, f7, L, H, mk(L,L,L,L,2'd0,2'd0,2'd0,3'd0,2'd0,H,H,L));
  endtask

  function automatic exp_t sample();
    logic ill;
`ifdef ILLEGAL_TRAP_EN
    ill = ifc.illegal_instr;
`else
    ill = 1'b0;
`endif
    return '{ifc.pc_write, ifc.adr_src, ifc.mem_w, ifc.ir_write, ifc.result_src,
             ifc.alu_src_a, ifc.alu_src_b, ifc.alu_control, ifc.imm_src,
             ifc.reg_w, ifc.instr_done, ill};
  endfunction

  initial begin
    vec_t cur;
    exp_t got;

    row("reset", H, RT, 3'd0, L, L, H, mk(L,L,L,L,2'd2,2'd0,2'd2,3'd0,2'd0,L,L,L));
    alu_instr("add",  RT, 3'b000, L, 2'd0, 3'b000);
    alu_instr("sub",  RT, 3'b000, H, 2'd0, 3'b001);
    row("fetch_stall", L, IT, 3'd0, H, L, L, mk(L,L,L,L,2'd2,2'd0,2'd2,3'd0,2'd0,L,L,L));
    alu_instr("addi", IT, 3'b000, H, 2'd1, 3'b000);
    alu_instr("slt",  RT, 3'b010, L, 2'd0, 3'b101);
    alu_instr("ori",  IT, 3'b110, L, 2'd1, 3'b011);
    alu_instr("and",  RT, 3'b111, L, 2'd0, 3'b010);
    alu_instr("xor",  RT, 3'b100, H, 2'd0, 3'b000);

    fd("lw", LW, 3'b010, L, L, 2'd0);
    row("lw_adr", L, LW, 3'b010, L, L, H, mk(L,L,L,L,2'd0,2'd2,2'd1,3'd0,2'd0,L,L,L));
    for (int unsigned i = 0; i < 3; i++)
      row("lw_wait", L, LW, 3'b010, L, L, L, mk(L,H,L,L,2'd0,2'd0,2'd0,3'd0,2'd0,L,L,L));
    row("lw_read", L, LW, 3'b010, L, L, H, mk(L,H,L,L,2'd0,2'd0,2'd0,3'd0,2'd0,L,L,L));
    row("lw_wb",   L, LW, 3'b010, L, L, H, mk(L,L,L,L,2'd1,2'd0,2'd0,3'd0,2'd0,H,H,L));

    fd("sw", SW, 3'b010, L, L, 2'd1);
    row("sw_adr",  L, SW, 3'b010, L, L, H, mk(L,L,L,L,2'd0,2'd2,2'd1,3'd0,2'd1,L,L,L));
    row("sw_wait", L, SW, 3'b010, L, L, L, mk(L,H,H,L,2'd0,2'd0,2'd0,3'd0,2'd1,L,L,L));
    row("sw_done", L, SW, 3'b010, L, L, H, mk(L,H,H,L,2'd0,2'd0,2'd0,3'd0,2'd1,L,H,L));

    fd("beq_t", BQ, 3'd0, L, H, 2'd2);
    row("beq_taken", L, BQ, 3'd0, L, H, H, mk(H,L,L,L,2'd0,2'd2,2'd0,3'd1,2'd2,L,H,L));
    fd("beq_n", BQ, 3'd0, L, L, 2'd2);
    row("beq_not",   L, BQ, 3'd0, L, L, H, mk(L,L,L,L,2'd0,2'd2,2'd0,3'd1,2'd2,L,H,L));

    fd("jal", JL, 3'd0, L, L, 2'd3);
    row("jal_exec", L, JL, 3'd0, L, L, H, mk(H,L,L,L,2'd0,2'd1,2'd2,3'd0,2'd3,L,L,L));
    row("jal_wb",   L, JL, 3'd0, L, L, H, mk(L,L,L,L,2'd0,2'd0,2'd0,3'd0,2'd3,H,H,L));

    fd("abort", RT, 3'd0, L, L, 2'd0);
    row("abort_rst",   H, RT, 3'd0, L, L, H, mk(L,L,L,L,2'd2,2'd0,2'd2,3'd0,2'd0,L,L,L));
    row("abort_fetch", L, RT, 3'd0, L, L, H, mk(H,L,L,H,2'd2,2'd0,2'd2,3'd0,2'd0,L,L,L));
    row("abort_dec",   L, RT, 3'd0, L, L, H, mk(L,L,L,L,2'd0,2'd1,2'd1,3'd0,2'd0,L,L,L));
    row("abort_exec",  L, RT, 3'd0, L, L, H, mk(L,L,L,L,2'd0,2'd2,2'd0,3'd0,2'd0,L,L,L));
    row("abort_wb",    L, RT, 3'd0, L, L, H, mk(L,L,L,L,2'd0,2'd0,2'd0,3'd0,2'd0,H,H,L));

    row("bad_fetch", L, BAD, 3'd0, L, H, H, mk(H,L,L,H,2'd2,2'd0,2'd2,3'd0,2'd0,L,L,L));
`ifdef ILLEGAL_TRAP_EN
    row("bad_decode", L, BAD, 3'd0, L, H, H, mk(L,L,L,L,2'd0,2'd1,2'd1,3'd0,2'd0,L,L,L));
    for (int unsigned i = 0; i < 3; i++)
      row("trap_hold", L, BAD, 3'd0, L, H, H, mk(L,L,L,L,2'd0,2'd0,2'd0,3'd0,2'd0,L,L,H));
    row("trap_rst",  H, BAD, 3'd0, L, H, H, mk(L,L,L,L,2'd2,2'd0,2'd2,3'd0,2'd0,L,L,L));
    row("trap_exit", L, RT,  3'd0, L, L, H, mk(H,L,L,H,2'd2,2'd0,2'd2,3'd0,2'd0,L,L,L));
`else
    row("bad_decode", L, BAD, 3'd0, L, H, H, mk(L,L,L,L,2'd0,2'd1,2'd1,3'd0,2'd0,L,H,L));
    row("bad_next",   L, RT,  3'd0, L, L, H, mk(H,L,L,H,2'd2,2'd0,2'd2,3'd0,2'd0,L,L,L));
`endif

    ifc.op = RT; ifc.funct3 = 3'd0; ifc.funct7b5 = 1'b0; ifc.zero = 1'b0; ifc.mem_ready = 1'b0;
    #1 srst = 1'b1;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      srst          = vecs[i].srst;
      ifc.op        = vecs[i].op;
      ifc.funct3    = vecs[i].f3;
      ifc.funct7b5  = vecs[i].f7;
      ifc.zero      = vecs[i].zero;
      ifc.mem_ready = vecs[i].mr;
      sb.push_back(vecs[i]);
      @(negedge clk);
      cur = sb.pop_front();
      got = sample();
      tests++;
      if (got !== cur.exp) begin
        failed++;
        $display("FAIL %s (row %0d): got %h expected %h", cur.name, i, got, cur.exp);
      end
      if (cur.srst) begin
        tests++;
        if ({ifc.pc_write, ifc.ir_write, ifc.reg_w, ifc.mem_w, ifc.instr_done} !== 5'b00000) begin
          failed++;
          $display("FAIL %s (row %0d): enable active during reset", cur.name, i);
        end
      end
      if (!cur.srst && !cur.mr) begin
        tests++;
        if ({ifc.reg_w, ifc.instr_done} !== 2'b00) begin
          failed++;
          $display("FAIL %s (row %0d): completion issued while mem_ready low", cur.name, i);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
